ip_misc_fifo_rd_stream: RTL and testbench

IP_MISC_FIFO_RD_STREAM -- requirements
Module: ip_misc_fifo_rd_stream

---
 rtl/ip_misc_fifo_rd_stream_if.sv | 25 ++
 rtl/ip_misc_fifo_rd_stream.sv | 87 ++++++++
 tb/tb_ip_misc_fifo_rd_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ip_misc_fifo_rd_stream_if.sv
// Read-side bundle between the async FIFO, the stream consumer and ip_misc_fifo_rd_stream.
// master is the adapter's view; slave is the view of whatever surrounds it.
interface ip_misc_fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_d_out;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [31:0]           word_cnt;

  modport master (
    input  fifo_empty, fifo_d_out, flush, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last, word_cnt
  );

  modport slave (
    output fifo_empty, fifo_d_out, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last, word_cnt
  );
endinterface

// File: rtl/ip_misc_fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter with a 2-entry skid buffer,
// packet framing (m_last every PKT_LEN words), a word counter and flush handling.
module ip_misc_fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 8
) (
  input  logic                       i_rd_clk,
  input  logic                       i_rst,
  ip_misc_fifo_rd_stream_if.master   bus
);

  typedef enum logic {StRun, StDrain} state_e;

  localparam logic [15:0] LastIdx = 16'(PKT_LEN - 1);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [15:0]           r_pkt_cnt;
  logic [31:0]           r_word_cnt;

  logic       w_valid;
  logic       w_pop;
  logic       w_wr;
  logic       w_wr_idx;
  logic       w_rd_en;
  logic [2:0] w_occ;

  always_comb begin
    w_valid  = (r_count != 2'd0) && !bus.flush;
    w_pop    = w_valid && bus.m_ready;
    // Entries that will be occupied after this edge, counting the word still in flight.
    w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd_en  = !i_rst && !bus.fifo_empty && !bus.flush && (r_state == StRun) && (w_occ < 3'd2);
    w_wr     = r_inflight && (r_state == StRun) && !bus.flush;
    w_wr_idx = (r_count == 2'd1) && !w_pop;
  end

  always_ff @(posedge i_rd_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StRun;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_pkt_cnt  <= 16'd0;
      r_word_cnt <= 32'd0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (bus.flush) begin
            r_count   <= 2'd0;
            r_pkt_cnt <= 16'd0;
            r_state   <= r_inflight ? StDrain : StRun;
          end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
              r_buf0     <= r_buf1;
              r_word_cnt <= r_word_cnt + 32'd1;
              r_pkt_cnt  <= (r_pkt_cnt == LastIdx) ? 16'd0 : r_pkt_cnt + 16'd1;
            end
            // A write into slot 0 overrides the shift above, keeping order on pop+write.
            if (w_wr) begin
              if (w_wr_idx) r_buf1 <= bus.fifo_d_out;
              else          r_buf0 <= bus.fifo_d_out;
            end
            r_count <= r_count + 2'(w_wr) - 2'(w_pop);
          end
        end
        StDrain: begin
          r_inflight <= 1'b0;
          r_state    <= StRun;
          if (bus.flush) r_pkt_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = r_buf0;
  assign bus.m_last     = w_valid && (r_pkt_cnt == LastIdx);
  assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_ip_misc_fifo_rd_stream.sv
// Bench for ip_misc_fifo_rd_stream: cycle table on a PKT_LEN=8 instance driven directly,
// plus FIFO-model sequences on a PKT_LEN=3 instance for framing and mid-burst reset.
module tb_ip_misc_fifo_rd_stream;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  ip_misc_fifo_rd_stream_if #(.DATA_WIDTH(DW)) if_a ();
  ip_misc_fifo_rd_stream_if #(.DATA_WIDTH(DW)) if_b ();

  ip_misc_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(8)) dut_a (
    .i_rd_clk (clk),
    .i_rst    (rst_a),
    .bus      (if_a)
  );

  ip_misc_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(3)) dut_b (
    .i_rd_clk (clk),
    .i_rst    (rst_b),
    .bus      (if_b)
  );

  // FIFO model for instance B: one-cycle read latency, garbage when not read.
  logic [31:0] fmem [64];
  int unsigned f_wr = 0;
  int unsigned f_rd = 0;
  assign if_b.fifo_empty = (f_wr == f_rd);
  always @(posedge clk) begin
    if (if_b.fifo_rd_en) begin
      if_b.fifo_d_out <= fmem[f_rd[5:0]];
      f_rd            <= f_rd + 1;
    end else begin
      if_b.fifo_d_out <= 32'hDEAD_BEEF;
    end
  end

  task automatic push_b(input logic [31:0] v);
    fmem[f_wr[5:0]] = v;
    f_wr = f_wr + 1;
  endtask

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        empty;
    logic        ready;
    logic        flush;
    logic [31:0] dout;
    logic        rd_en;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic [31:0] wc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic r, input logic f, input logic [31:0] dout,
                     input logic rd, input logic v, input logic [31:0] d, input logic l,
                     input logic [31:0] wc);
    vec_t t;
    t.empty = e; t.ready = r; t.flush = f; t.dout = dout;
    t.rd_en = rd; t.valid = v; t.data = d; t.last = l; t.wc = wc;
    vq.push_back(t);
  endtask

  // Collects n_words pops from B, checking order against the FIFO model contents and framing.
  task automatic collect_b(input int unsigned n_words, input int unsigned first,
                           input int unsigned pkt_start, input string tag);
    int unsigned got = 0;
    for (int c = 0; c < 80 && got < n_words; c++) begin
      @(negedge clk);
      if (if_b.m_valid && if_b.m_ready) begin
        chk($sformatf("%s data%0d", tag, got), if_b.m_data, fmem[6'(first + got)]);
        chk($sformatf("%s last%0d", tag, got), {31'b0, if_b.m_last},
            {31'b0, ((pkt_start + got) % 3) == 2});
        got++;
      end
    end
    chk($sformatf("%s pop count", tag), got, n_words);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned start;
    int unsigned remaining;

    // empty, ready, flush, dout | rd_en, valid, data, last, word_cnt
    add(1, 1, 0, 'h00, 0, 0, 'h00, 0, 0);
    add(1, 1, 0, 'h00, 0, 0, 'h00, 0, 0);
    add(0, 1, 0, 'h00, 1, 0, 'h00, 0, 0);
    add(0, 1, 0, 'h11, 1, 0, 'h00, 0, 0);
    add(0, 1, 0, 'h12, 1, 1, 'h11, 0, 0);
    add(0, 1, 0, 'h13, 1, 1, 'h12, 0, 1);
    add(0, 1, 0, 'h14, 1, 1, 'h13, 0, 2);
    add(0, 1, 0, 'h15, 1, 1, 'h14, 0, 3);
    add(0, 1, 0, 'h16, 1, 1, 'h15, 0, 4);
    add(0, 1, 0, 'h17, 1, 1, 'h16, 0, 5);
    add(1, 1, 0, 'h18, 0, 1, 'h17, 0, 6);
    add(1, 1, 0, 'h00, 0, 1, 'h18, 1, 7);
    add(1, 1, 0, 'h00, 0, 0, 'h00, 0, 8);
    // backpressure for 5 cycles
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 8);
    add(0, 0, 0, 'h21, 1, 0, 'h00, 0, 8);
    add(0, 0, 0, 'h22, 0, 1, 'h21, 0, 8);
    add(0, 0, 0, 'h00, 0, 1, 'h21, 0, 8);
    add(0, 0, 0, 'h00, 0, 1, 'h21, 0, 8);
    add(0, 1, 0, 'h00, 1, 1, 'h21, 0, 8);
    add(1, 1, 0, 'h23, 0, 1, 'h22, 0, 9);
    add(1, 1, 0, 'h00, 0, 1, 'h23, 0, 10);
    add(1, 1, 0, 'h00, 0, 0, 'h00, 0, 11);
    // flush with one word buffered and one in flight
    add(0, 0, 0, 'h00, 1, 0, 'h00, 0, 11);
    add(0, 0, 0, 'h31, 1, 0, 'h00, 0, 11);
    add(0, 1, 1, 'h32, 0, 0, 'h00, 0, 11);
    add(0, 1, 0, 'h99, 0, 0, 'h00, 0, 11);
    add(0, 1, 0, 'h00, 1, 0, 'h00, 0, 11);
    add(1, 1, 0, 'h33, 0, 0, 'h00, 0, 11);
    add(1, 1, 0, 'h00, 0, 1, 'h33, 0, 11);
    add(1, 1, 0, 'h00, 0, 0, 'h00, 0, 12);

    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.fifo_empty = 1'b0;
    if_a.m_ready    = 1'b1;
    if_a.flush      = 1'b0;
    if_a.fifo_d_out = '0;
    if_b.m_ready    = 1'b1;
    if_b.flush      = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rd_en", {31'b0, if_a.fifo_rd_en}, 32'd0);
    chk("reset valid", {31'b0, if_a.m_valid}, 32'd0);
    chk("reset last", {31'b0, if_a.m_last}, 32'd0);
    chk("reset data", if_a.m_data, 32'd0);
    chk("reset word_cnt", if_a.word_cnt, 32'd0);

    @(posedge clk);
    #1;
    if_a.fifo_empty = 1'b1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      if_a.fifo_empty = vq[i].empty;
      if_a.m_ready    = vq[i].ready;
      if_a.flush      = vq[i].flush;
      if_a.fifo_d_out = vq[i].dout;
      @(negedge clk);
      chk($sformatf("row%0d rd_en", i), {31'b0, if_a.fifo_rd_en}, {31'b0, vq[i].rd_en});
      chk($sformatf("row%0d valid", i), {31'b0, if_a.m_valid}, {31'b0, vq[i].valid});
      chk($sformatf("row%0d last", i), {31'b0, if_a.m_last}, {31'b0, vq[i].last});
      chk($sformatf("row%0d word_cnt", i), if_a.word_cnt, vq[i].wc);
      if (vq[i].valid) chk($sformatf("row%0d data", i), if_a.m_data, vq[i].data);
    end

    // PKT_LEN=3: seven words, m_last on the 3rd and 6th
    @(posedge clk);
    #1;
    base = f_wr;
    for (int i = 0; i < 7; i++) push_b(32'h41 + 32'(i));
    collect_b(7, base, 0, "pkt3");
    @(negedge clk);
    chk("pkt3 word_cnt", if_b.word_cnt, 32'd7);
    chk("pkt3 idle valid", {31'b0, if_b.m_valid}, 32'd0);

    // Reset in the middle of a burst; packet counter sits at 1 after seven pops
    @(posedge clk);
    #1;
    base = f_wr;
    for (int i = 0; i < 10; i++) push_b(32'h51 + 32'(i));
    collect_b(3, base, 1, "burst");
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d rd_en", i), {31'b0, if_b.fifo_rd_en}, 32'd0);
      chk($sformatf("rst%0d valid", i), {31'b0, if_b.m_valid}, 32'd0);
      chk($sformatf("rst%0d last", i), {31'b0, if_b.m_last}, 32'd0);
      chk($sformatf("rst%0d data", i), if_b.m_data, 32'd0);
      chk($sformatf("rst%0d word_cnt", i), if_b.word_cnt, 32'd0);
    end
    @(posedge clk);
    #1;
    start     = f_rd;
    remaining = f_wr - f_rd;
    rst_b     = 1'b0;
    collect_b(remaining, start, 0, "resume");
    @(negedge clk);
    chk("resume word_cnt", if_b.word_cnt, remaining);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
